// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and active-low segment patterns {g,f,e,d,c,b,a} for the 7-segment scan driver.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit-in / display-out bundle of the scan driver; master supplies digits, slave drives the display.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  bcd_digit_t s0;
  bcd_digit_t s1;
  bcd_digit_t s2;
  bcd_digit_t s3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output s0, s1, s2, s3, input an, seg, dp);
  modport slave  (input s0, s1, s2, s3, output an, seg, dp);

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_digit_t bcd,
  output logic [6:0] seg
);

  // Pattern lookup
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode 4-digit display with once-per-frame digit snapshot.
// Optional leading-zero blanking above the decimal point is enabled by LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DP_DIGIT    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  bcd_digit_t s0,
  input  bcd_digit_t s1,
  input  bcd_digit_t s2,
  input  bcd_digit_t s3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int              CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [1:0]       DP_IDX  = 2'(DP_DIGIT);

  logic [CNT_W-1:0]                cnt_r;
  logic [1:0]                      idx_r;
  bcd_digit_t [NUM_DIGITS-1:0]     snap_r;
  logic                            tick_s;
  logic                            blank_s;
  bcd_digit_t                      digit_s;
  logic [6:0]                      dec_s;
  logic [6:0]                      seg_s;

  assign tick_s  = (cnt_r == CNT_MAX);
  assign digit_s = snap_r[idx_r];

  bcd_to_seg7 u_dec (
    .bcd (digit_s),
    .seg (dec_s)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic higher_zero_s;

  // Blank the current slot when it and every more significant digit are zero, above the point only
  always_comb begin
    blank_s       = 1'b0;
    higher_zero_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero_s = higher_zero_s & (snap_r[i] == 4'd0);
      if ((i > DP_DIGIT) && (i == int'(idx_r)) && higher_zero_s) begin
        blank_s = 1'b1;
      end else begin
        blank_s = blank_s;
      end
    end
  end
`else
  assign blank_s = 1'b0;
`endif

  assign seg_s = blank_s ? SEG_BLANK : dec_s;

  // Divider, slot index, frame snapshot and registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= '0;
      idx_r  <= 2'd0;
      snap_r <= '0;
      an     <= 4'b1111;
      seg    <= SEG_BLANK;
      dp     <= 1'b1;
    end else begin
      cnt_r <= tick_s ? '0 : cnt_r + CNT_W'(1);
      if (tick_s) begin
        idx_r <= idx_r + 2'd1;
      end
      // Capture the next frame only as the scan wraps, so a frame is never torn
      if (tick_s && (idx_r == 2'd3)) begin
        snap_r <= {s3, s2, s1, s0};
      end
      an  <= ~(4'b0001 << idx_r);
      seg <= seg_s;
      dp  <= (idx_r == DP_IDX) ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a cycle-count reference model predicts every display output; a negedge monitor checks them.
module tb_seg7_scan_driver;

  localparam int R   = 4;
  localparam int DPD = 2;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_scan_driver_if ifc();

  seg7_scan_driver #(.REFRESH_DIV(R), .DP_DIGIT(DPD)) dut (
    .clk   (clk),
    .reset (reset),
    .s0    (ifc.s0),
    .s1    (ifc.s1),
    .s2    (ifc.s2),
    .s3    (ifc.s3),
    .an    (ifc.an),
    .seg   (ifc.seg),
    .dp    (ifc.dp)
  );

  exp_t       expq[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         m = 0;
  int         snap[4];
  logic [6:0] seg_tab[16];

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b0111111;
    for (int k = 0; k < 4; k++) snap[k] = 0;
  end

  // Monitor: one expected record per clock edge
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      vectors++;
      if ((ifc.an !== e.an) || (ifc.seg !== e.seg) || (ifc.dp !== e.dp)) begin
        miscompares++;
        $display("FAIL scan_out t=%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 $time, ifc.an, ifc.seg, ifc.dp, e.an, e.seg, e.dp);
      end
    end
  end

  // Apply one cycle of inputs and predict the outputs after the coming edge
  task automatic step(input logic rst, input int d3, input int d2, input int d1, input int d0);
    exp_t       e;
    int         idx;
    logic [3:0] onehot;
    logic       all_zero;
    reset  = rst;
    ifc.s3 = 4'(d3);
    ifc.s2 = 4'(d2);
    ifc.s1 = 4'(d1);
    ifc.s0 = 4'(d0);
    if (rst) begin
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      e.dp  = 1'b1;
      m = 0;
      for (int k = 0; k < 4; k++) snap[k] = 0;
    end else begin
      idx = (m / R) % 4;
      onehot = 4'b0000;
      onehot[idx] = 1'b1;
      e.an  = ~onehot;
      e.seg = seg_tab[snap[idx]];
      e.dp  = (idx == DPD) ? 1'b0 : 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      all_zero = 1'b1;
      for (int k = idx; k < 4; k++) if (snap[k] != 0) all_zero = 1'b0;
      if ((idx > DPD) && all_zero) e.seg = 7'b1111111;
`else
      all_zero = 1'b0;
`endif
      m++;
      if (m % (4 * R) == 0) begin
        snap[0] = d0; snap[1] = d1; snap[2] = d2; snap[3] = d3;
      end
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int d3, input int d2, input int d1, input int d0);
    for (int k = 0; k < n; k++) step(1'b0, d3, d2, d1, d0);
  endtask

  // Advance until the model's edge count sits at the given frame position
  task automatic run_to(input int pos, input int d3, input int d2, input int d1, input int d0);
    for (int k = 0; k < 4 * R; k++) begin
      if (m % (4 * R) == pos) break;
      step(1'b0, d3, d2, d1, d0);
    end
  endtask

  initial begin
    int r0, r1, r2, r3;
    for (int k = 0; k < 3; k++) step(1'b1, 1, 2, 3, 4);
    run(40, 1, 2, 3, 4);
    for (int v = 0; v < 16; v++) run(4 * R, 1, 2, 3, v);
    run(4 * R, 1, 2, 3, 0);
    run_to(0, 0, 0, 3, 0);
    run(4 * R, 0, 0, 3, 0);
    run_to(R + 1, 0, 0, 3, 0);
    run(2 * 4 * R, 0, 0, 7, 0);
    run_to(2 * R + 1, 4, 3, 2, 1);
    step(1'b1, 4, 3, 2, 1);
    run(20, 4, 3, 2, 1);
    run(3 * 4 * R, 0, 5, 0, 7);
    run(3 * 4 * R, 1, 5, 0, 7);
    r0 = 0; r1 = 0; r2 = 0; r3 = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) r0 = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) r1 = $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) r2 = $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) r3 = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 15);
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, r3, r2, r1, r0);
    end
    for (int k = 0; k < 10; k++) begin
      if (expq.size() == 0) break;
      @(posedge clk);
    end
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected records left unchecked, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
